// File: rtl/mem_arbiter.sv
// Arbitrates a shared single-port memory bus between instruction fetch and data load/store.
// One transaction at a time; registered bus outputs, wait-cycle abort, sticky error flag.
module mem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic [2:0]  read_mem,
  input  logic [1:0]  write_mem,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        stall,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;

  localparam logic LG_DATA  = 1'b0;
  localparam logic LG_FETCH = 1'b1;

  logic [1:0]  state;
  logic        last_grant;
  logic [7:0]  wait_cnt;
  logic [2:0]  cur_load;
  logic        cur_store;
  logic [1:0]  cur_off;

  logic        data_pend;
  logic        is_store;
  logic        grant_data;
  logic        grant_fetch;
  logic        bad_align;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Unknown load codes are handled as lw: word alignment, no extension.
  function automatic logic misaligned(input logic [2:0] rd, input logic [1:0] wr,
                                      input logic [1:0] off);
    logic m;
    m = 1'b0;
    if (wr != 2'b00) begin
      case (wr)
        2'b01:   m = (off != 2'b00);
        2'b10:   m = off[0];
        default: m = 1'b0;
      endcase
    end else begin
      case (rd)
        3'b111, 3'b011: m = 1'b0;
        3'b110, 3'b010: m = off[0];
        default:        m = (off != 2'b00);
      endcase
    end
    return m;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] rd, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> {off, 3'b000};
    case (rd)
      3'b111:  res = {{24{lane[7]}}, lane[7:0]};
      3'b011:  res = {24'h000000, lane[7:0]};
      3'b110:  res = {{16{lane[15]}}, lane[15:0]};
      3'b010:  res = {16'h0000, lane[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  assign data_pend   = (read_mem != 3'b000) || (write_mem != 2'b00);
  assign is_store    = (write_mem != 2'b00);
  assign grant_data  = data_pend && (!if_req || (last_grant == LG_FETCH));
  assign grant_fetch = if_req && (!data_pend || (last_grant == LG_DATA));
  assign bad_align   = misaligned(read_mem, write_mem, mem_addr[1:0]);
  assign stall       = (data_pend && !mem_done) || (if_req && !if_valid);

  // Byte enables and lane-replicated store data for the pending store.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_wdata;
    case (write_mem)
      2'b10: begin
        st_be    = 4'b0011 << mem_addr[1:0];
        st_wdata = {2{mem_wdata[15:0]}};
      end
      2'b11: begin
        st_be    = 4'b0001 << mem_addr[1:0];
        st_wdata = {4{mem_wdata[7:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = mem_wdata;
      end
    endcase
  end

  // Arbitration FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LG_FETCH;
      wait_cnt   <= 8'd0;
      cur_load   <= 3'b000;
      cur_store  <= 1'b0;
      cur_off    <= 2'b00;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= 4'b0000;
      bus_addr   <= 32'h0000_0000;
      bus_wdata  <= 32'h0000_0000;
      if_valid   <= 1'b0;
      mem_done   <= 1'b0;
      if_rdata   <= 32'h0000_0000;
      mem_rdata  <= 32'h0000_0000;
      err        <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      if_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A done pulse blocks granting in its own cycle.
          if (!mem_done && !if_valid) begin
            if (grant_data) begin
              last_grant <= LG_DATA;
              if (bad_align) begin
                err       <= 1'b1;
                mem_done  <= 1'b1;
                mem_rdata <= 32'h0000_0000;
              end else begin
                state     <= DATA;
                bus_req   <= 1'b1;
                bus_we    <= is_store;
                bus_addr  <= mem_addr & 32'hFFFF_FFFC;
                bus_be    <= is_store ? st_be : 4'b1111;
                bus_wdata <= is_store ? st_wdata : 32'h0000_0000;
                wait_cnt  <= 8'd0;
                cur_load  <= read_mem;
                cur_store <= is_store;
                cur_off   <= mem_addr[1:0];
              end
            end else if (grant_fetch) begin
              last_grant <= LG_FETCH;
              state      <= FETCH;
              bus_req    <= 1'b1;
              bus_we     <= 1'b0;
              bus_addr   <= if_addr & 32'hFFFF_FFFC;
              bus_be     <= 4'b1111;
              wait_cnt   <= 8'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        DATA, FETCH: begin
          if (bus_ready) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (state == DATA) begin
              mem_done  <= 1'b1;
              mem_rdata <= cur_store ? 32'h0000_0000 : load_ext(cur_load, cur_off, bus_rdata);
            end else begin
              if_valid <= 1'b1;
              if_rdata <= bus_rdata;
            end
          end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            err     <= 1'b1;
            if (state == DATA) begin
              mem_done  <= 1'b1;
              mem_rdata <= 32'h0000_0000;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= 32'h0000_0000;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level expectation queue checked every
// cycle, plus literal expectations on the headline vectors.
module tb_mem_arbiter;

  localparam int MAXW = 15;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid;
  logic [2:0]  read_mem;
  logic [1:0]  write_mem;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        stall, err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .read_mem(read_mem), .write_mem(write_mem), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fetch;
    logic        has_bus;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  typedef struct {
    logic [2:0]  rm;
    logic [1:0]  wm;
    logic [31:0] addr, wd, word;
    logic        rdy;
    logic [31:0] l_addr;
    logic [3:0]  l_be;
    logic [31:0] l_wdata, l_rdata;
  } vec_t;

  txn_t exp_q[$];
  logic m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour from the load/store rules, using plain arithmetic.
  function automatic logic [31:0] m_load(logic [2:0] rm, logic [1:0] off, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (int'(off) * 8)) & 32'h0000_00FF;
    h = (w >> (int'(off) * 8)) & 32'h0000_FFFF;
    case (rm)
      3'b111:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b110:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b011:  return b;
      3'b010:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] wm, logic [1:0] off);
    case (wm)
      2'b10:   return (off >= 2'd2) ? 4'b1100 : 4'b0011;
      2'b11:   return (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                      (off == 2'd2) ? 4'b0100 : 4'b1000;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] wm, logic [31:0] d);
    case (wm)
      2'b10:   return (d & 32'h0000_FFFF) * 32'h0001_0001;
      2'b11:   return (d & 32'h0000_00FF) * 32'h0101_0101;
      default: return d;
    endcase
  endfunction

  function automatic logic m_mis(logic [2:0] rm, logic [1:0] wm, logic [1:0] off);
    if (wm == 2'b01 || (wm == 2'b00 && rm == 3'b001)) return off != 2'd0;
    if (wm == 2'b10 || (wm == 2'b00 && (rm == 3'b110 || rm == 3'b010))) return off[0];
    return 1'b0;
  endfunction

  task automatic push_data(input logic [2:0] rm, input logic [1:0] wm, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] w, input logic rdy);
    txn_t t;
    logic st;
    st        = (wm != 2'b00);
    t.fetch   = 1'b0;
    t.has_bus = !m_mis(rm, wm, a[1:0]);
    t.addr    = a - (a % 32'd4);
    t.be      = st ? m_be(wm, a[1:0]) : 4'b1111;
    t.wdata   = m_wdata(wm, wd);
    t.we      = st;
    t.rdata   = (!t.has_bus || !rdy || st) ? 32'h0 : m_load(rm, a[1:0], w);
    if (!t.has_bus || !rdy) m_err = 1'b1;
    t.err     = m_err;
    exp_q.push_back(t);
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] w, input logic rdy);
    txn_t t;
    t.fetch = 1'b1; t.has_bus = 1'b1; t.addr = a - (a % 32'd4); t.be = 4'b1111;
    t.wdata = 32'h0; t.we = 1'b0; t.rdata = rdy ? w : 32'h0;
    if (!rdy) m_err = 1'b1;
    t.err = m_err;
    exp_q.push_back(t);
  endtask

  // Every cycle: bus fields against the head transaction; each done pops and is checked.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req) begin
        if (exp_q.size() == 0) begin
          chk("bus_req_unexpected", 32'(bus_req), 32'h0);
        end else begin
          chk("bus_allowed", 32'(bus_req), 32'(exp_q[0].has_bus));
          chk("bus_addr", bus_addr, exp_q[0].addr);
          chk("bus_be", 32'(bus_be), 32'(exp_q[0].be));
          chk("bus_we", 32'(bus_we), 32'(exp_q[0].we));
          if (exp_q[0].we) chk("bus_wdata", bus_wdata, exp_q[0].wdata);
        end
      end
      if (mem_done || if_valid) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", {30'h0, mem_done, if_valid}, 32'h0);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("done_kind", {30'h0, mem_done, if_valid}, t.fetch ? 32'h1 : 32'h2);
          chk("done_rdata", t.fetch ? if_rdata : mem_rdata, t.rdata);
          chk("done_err", 32'(err), 32'(t.err));
        end
      end
    end
  end

  vec_t vecs[14];

  task automatic run_data(input vec_t v, input string name);
    int lat, nbus, exp_lat, exp_bus;
    logic got, mis;
    mis     = m_mis(v.rm, v.wm, v.addr[1:0]);
    exp_lat = mis ? 1 : (v.rdy ? 2 : MAXW + 1);
    exp_bus = mis ? 0 : (v.rdy ? 1 : MAXW);
    @(negedge clk);
    push_data(v.rm, v.wm, v.addr, v.wd, v.word, v.rdy);
    read_mem = v.rm; write_mem = v.wm; mem_addr = v.addr; mem_wdata = v.wd;
    bus_rdata = v.word; bus_ready = v.rdy;
    #1 chk({name, "_stall_req"}, 32'(stall), 32'h1);
    got = 1'b0; lat = 0; nbus = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (bus_req) begin
        if (nbus == 0) begin
          chk({name, "_lit_addr"}, bus_addr, v.l_addr);
          chk({name, "_lit_be"}, 32'(bus_be), 32'(v.l_be));
          if (v.wm != 2'b00) chk({name, "_lit_wdata"}, bus_wdata, v.l_wdata);
        end
        nbus++;
      end
      if (mem_done) begin got = 1'b1; lat = i; end
    end
    if (!got) begin
      chk({name, "_done_timeout"}, 32'h0, 32'h1);
    end else begin
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_bus_cycles"}, 32'(nbus), 32'(exp_bus));
      chk({name, "_lit_rdata"}, mem_rdata, v.l_rdata);
      chk({name, "_stall_done"}, 32'(stall), 32'h0);
    end
    read_mem = 3'b000; write_mem = 2'b00; bus_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; read_mem = 3'b000; write_mem = 2'b00;
    mem_addr = 32'h0; mem_wdata = 32'h0; bus_rdata = 32'h0; bus_ready = 1'b1;
    #2;
    chk("rst_outs", {bus_req, bus_we, if_valid, mem_done, err, bus_be},
        32'h0);
    chk("rst_words", bus_addr | bus_wdata | if_rdata | mem_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //            rm      wm      addr        wd            word          rdy  l_addr      l_be     l_wdata       l_rdata
    vecs[0]  = '{3'b111, 2'b00, 32'h103, 32'h0,        32'h80FF1234, 1'b1, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80};
    vecs[1]  = '{3'b011, 2'b00, 32'h103, 32'h0,        32'h80FF1234, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h00000080};
    vecs[2]  = '{3'b110, 2'b00, 32'h102, 32'h0,        32'h80FF1234, 1'b1, 32'h100, 4'b1111, 32'h0,        32'hFFFF80FF};
    vecs[3]  = '{3'b010, 2'b00, 32'h102, 32'h0,        32'h80FF1234, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h000080FF};
    vecs[4]  = '{3'b001, 2'b00, 32'h100, 32'h0,        32'h80FF1234, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h80FF1234};
    vecs[5]  = '{3'b111, 2'b00, 32'h101, 32'h0,        32'h80FF1234, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h00000012};
    vecs[6]  = '{3'b000, 2'b10, 32'h202, 32'h0000BEEF, 32'h0,        1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0};
    vecs[7]  = '{3'b000, 2'b11, 32'h301, 32'h000000A5, 32'h0,        1'b1, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{3'b000, 2'b01, 32'h400, 32'hDEADBEEF, 32'h0,        1'b1, 32'h400, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[9]  = '{3'b001, 2'b11, 32'h503, 32'h0000007F, 32'h0,        1'b1, 32'h500, 4'b1000, 32'h7F7F7F7F, 32'h0};
    vecs[10] = '{3'b001, 2'b00, 32'h001, 32'h0,        32'h11111111, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[11] = '{3'b110, 2'b00, 32'h203, 32'h0,        32'h11111111, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[12] = '{3'b000, 2'b01, 32'h002, 32'h12345678, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[13] = '{3'b001, 2'b00, 32'h800, 32'h0,        32'h22222222, 1'b0, 32'h800, 4'b1111, 32'h0,        32'h0};

    for (int i = 0; i < 10; i++) run_data(vecs[i], $sformatf("vec%0d", i));
    chk("err_clean", 32'(err), 32'h0);

    // Fetch only: bus_req one cycle after the request, if_valid the cycle after that.
    begin
      int t_bus, t_val;
      t_bus = 0; t_val = 0;
      @(negedge clk);
      push_fetch(32'h0, 32'h00500093, 1'b1);
      if_req = 1'b1; if_addr = 32'h0; bus_rdata = 32'h00500093; bus_ready = 1'b1;
      for (int i = 1; i <= 40 && t_val == 0; i++) begin
        @(negedge clk);
        if (bus_req && t_bus == 0) t_bus = i;
        if (if_valid) begin
          t_val = i;
          chk("fetch_lit_rdata", if_rdata, 32'h00500093);
          chk("fetch_stall_done", 32'(stall), 32'h0);
        end
      end
      chk("fetch_bus_cycle", 32'(t_bus), 32'h1);
      chk("fetch_valid_cycle", 32'(t_val), 32'h2);
      if_req = 1'b0;
    end

    // Both held: last grant was the fetch, so data first, then strict alternation.
    begin
      int ndone;
      logic [3:0] order;
      ndone = 0; order = 4'b0000;
      @(negedge clk);
      push_data(3'b001, 2'b00, 32'h600, 32'h0, 32'h12345678, 1'b1);
      push_fetch(32'h700, 32'h12345678, 1'b1);
      push_data(3'b001, 2'b00, 32'h600, 32'h0, 32'h12345678, 1'b1);
      push_fetch(32'h700, 32'h12345678, 1'b1);
      if_req = 1'b1; if_addr = 32'h700; read_mem = 3'b001; mem_addr = 32'h600;
      bus_rdata = 32'h12345678;
      for (int i = 0; i < 60 && ndone < 4; i++) begin
        @(negedge clk);
        chk("alt_stall", 32'(stall), 32'h1);
        if (if_valid || mem_done) begin
          order[ndone] = if_valid;
          ndone++;
        end
      end
      chk("alt_count", 32'(ndone), 32'h4);
      chk("alt_order", 32'(order), 32'b1010);
      if_req = 1'b0; read_mem = 3'b000;
    end

    for (int i = 10; i < 14; i++) run_data(vecs[i], $sformatf("vec%0d", i));
    chk("err_sticky", 32'(err), 32'h1);

    // Asynchronous reset in the middle of a data access.
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      push_data(3'b001, 2'b00, 32'h900, 32'h0, 32'h33333333, 1'b0);
      read_mem = 3'b001; mem_addr = 32'h900; bus_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busreq", 32'(bus_req), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_outs", {bus_req, bus_we, if_valid, mem_done, err, bus_be}, 32'h0);
      chk("rst_async_words", bus_addr | bus_wdata | if_rdata | mem_rdata, 32'h0);
      exp_q.delete();
      m_err = 1'b0;
      read_mem = 3'b000; bus_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (mem_done || if_valid || bus_req) pulses++;
      end
      chk("post_rst_quiet", 32'(pulses), 32'h0);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
